// File: rtl/key_debounce_if.sv
// Key debouncer bus: raw key levels in, debounced level and press/release
// pulses out. The board-side driver of key_in uses the master modport; the
// debouncer uses the slave modport.
interface key_debounce_if #(
   parameter int NKEYS = 2
);
   logic [NKEYS-1:0] key_in;
   logic [NKEYS-1:0] key_level;
   logic [NKEYS-1:0] key_press;
   logic [NKEYS-1:0] key_release;

   modport master (
      output key_in,
      input  key_level,
      input  key_press,
      input  key_release
   );

   modport slave (
      input  key_in,
      output key_level,
      output key_press,
      output key_release
   );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: per-key 2-FF synchronizer, polarity normalisation and a
// four-state debounce FSM with optional hold-to-auto-repeat. Every key has
// its own counters. Pipeline: 2 synchronizer stages, the FSM qualification
// window, then one output register, so a clean press appears on key_press
// DEBOUNCE_CYC+3 cycles after the raw edge.
module key_debounce #(
   parameter int NKEYS          = 2,
   parameter int DEBOUNCE_CYC   = 1000000,
   parameter int REPEAT_DLY_CYC = 25000000,
   parameter int REPEAT_CYC     = 5000000,
   parameter int ACTIVE_LOW     = 1
) (
   input  logic          mclk,
   input  logic          reset,
   key_debounce_if.slave kb
);

   // Counter width covers the largest terminal count (the counters only
   // ever hold values up to count-1).
   localparam int MAX_A   = (DEBOUNCE_CYC > REPEAT_DLY_CYC) ? DEBOUNCE_CYC : REPEAT_DLY_CYC;
   localparam int MAX_CNT = (MAX_A > REPEAT_CYC) ? MAX_A : REPEAT_CYC;
   localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = (REPEAT_DLY_CYC > 0) ? CNT_W'(REPEAT_DLY_CYC - 1) : CNT_W'(0);
   localparam logic [CNT_W-1:0] RPT_LAST = (REPEAT_CYC > 0) ? CNT_W'(REPEAT_CYC - 1) : CNT_W'(0);
   localparam logic             RPT_EN   = (REPEAT_DLY_CYC != 0) ? 1'b1 : 1'b0;

   // Raw level of a released key; the synchronizer is reset to it so that a
   // key held through reset is seen as a fresh press afterwards.
   localparam logic [NKEYS-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? {NKEYS{1'b1}} : {NKEYS{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DB_PRESS = 2'd1,
      ST_HELD     = 2'd2,
      ST_DB_REL   = 2'd3
   } state_t;

   // Synchronizer stages (raw polarity).
   logic [NKEYS-1:0] r_sync1;
   logic [NKEYS-1:0] r_sync2;
   // Normalised synchronized key: 1 = pressed.
   logic [NKEYS-1:0] w_s;

   // Per-key FSM state and counters.
   state_t           r_state [NKEYS];
   logic [CNT_W-1:0] r_dcnt  [NKEYS];
   logic [CNT_W-1:0] r_rcnt  [NKEYS];
   logic [NKEYS-1:0] r_first;      // 1 = next repeat uses the initial delay
   logic [NKEYS-1:0] r_press_evt;  // FSM accepted a press or a repeat
   logic [NKEYS-1:0] r_rel_evt;    // FSM accepted a release

   state_t           w_state_nxt [NKEYS];
   logic [CNT_W-1:0] w_dcnt_nxt  [NKEYS];
   logic [CNT_W-1:0] w_rcnt_nxt  [NKEYS];
   logic [NKEYS-1:0] w_first_nxt;
   logic [NKEYS-1:0] w_press_nxt;
   logic [NKEYS-1:0] w_rel_nxt;

   // Registered outputs.
   logic [NKEYS-1:0] r_key_level;
   logic [NKEYS-1:0] r_key_press;
   logic [NKEYS-1:0] r_key_release;

   // Two-stage synchronizer for the asynchronous raw key levels.
   always_ff @(posedge mclk) begin
      if (reset) begin
         r_sync1 <= RAW_IDLE;
         r_sync2 <= RAW_IDLE;
      end else begin
         r_sync1 <= kb.key_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

   // FSM state and counter registers.
   always_ff @(posedge mclk) begin
      if (reset) begin
         for (int i = 0; i < NKEYS; i++) begin
            r_state[i] <= ST_IDLE;
            r_dcnt[i]  <= CNT_ZERO;
            r_rcnt[i]  <= CNT_ZERO;
         end
         r_first     <= {NKEYS{1'b1}};
         r_press_evt <= {NKEYS{1'b0}};
         r_rel_evt   <= {NKEYS{1'b0}};
      end else begin
         for (int i = 0; i < NKEYS; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_dcnt[i]  <= w_dcnt_nxt[i];
            r_rcnt[i]  <= w_rcnt_nxt[i];
         end
         r_first     <= w_first_nxt;
         r_press_evt <= w_press_nxt;
         r_rel_evt   <= w_rel_nxt;
      end
   end

   // Next-state, counter and event decode for every key.
   always_comb begin
      w_first_nxt = r_first;
      w_press_nxt = {NKEYS{1'b0}};
      w_rel_nxt   = {NKEYS{1'b0}};
      for (int i = 0; i < NKEYS; i++) begin
         w_state_nxt[i] = r_state[i];
         w_dcnt_nxt[i]  = r_dcnt[i];
         w_rcnt_nxt[i]  = r_rcnt[i];
         case (r_state[i])
            ST_IDLE: begin
               if (w_s[i]) begin
                  w_state_nxt[i] = ST_DB_PRESS;
                  w_dcnt_nxt[i]  = CNT_ONE;
               end else begin
                  w_dcnt_nxt[i]  = CNT_ZERO;
               end
            end
            ST_DB_PRESS: begin
               if (!w_s[i]) begin
                  // Bounce rejected: back to idle without a pulse.
                  w_state_nxt[i] = ST_IDLE;
                  w_dcnt_nxt[i]  = CNT_ZERO;
               end else if (r_dcnt[i] == DB_LAST) begin
                  w_state_nxt[i] = ST_HELD;
                  w_dcnt_nxt[i]  = CNT_ZERO;
                  w_rcnt_nxt[i]  = CNT_ZERO;
                  w_first_nxt[i] = 1'b1;
                  w_press_nxt[i] = 1'b1;
               end else begin
                  w_dcnt_nxt[i]  = r_dcnt[i] + CNT_ONE;
               end
            end
            ST_HELD: begin
               if (!w_s[i]) begin
                  w_state_nxt[i] = ST_DB_REL;
                  w_dcnt_nxt[i]  = CNT_ONE;
               end else if (RPT_EN) begin
                  // Compare-and-clear: the first repeat waits the initial
                  // delay, later ones the shorter repeat period.
                  if (r_first[i] ? (r_rcnt[i] == DLY_LAST) : (r_rcnt[i] == RPT_LAST)) begin
                     w_rcnt_nxt[i]  = CNT_ZERO;
                     w_first_nxt[i] = 1'b0;
                     w_press_nxt[i] = 1'b1;
                  end else begin
                     w_rcnt_nxt[i]  = r_rcnt[i] + CNT_ONE;
                  end
               end else begin
                  w_rcnt_nxt[i]  = CNT_ZERO;
               end
            end
            ST_DB_REL: begin
               if (w_s[i]) begin
                  // Release bounce: resume holding with the repeat phase
                  // restarted from the initial delay.
                  w_state_nxt[i] = ST_HELD;
                  w_dcnt_nxt[i]  = CNT_ZERO;
                  w_rcnt_nxt[i]  = CNT_ZERO;
                  w_first_nxt[i] = 1'b1;
               end else if (r_dcnt[i] == DB_LAST) begin
                  w_state_nxt[i] = ST_IDLE;
                  w_dcnt_nxt[i]  = CNT_ZERO;
                  w_rel_nxt[i]   = 1'b1;
               end else begin
                  w_dcnt_nxt[i]  = r_dcnt[i] + CNT_ONE;
               end
            end
            default: begin
               w_state_nxt[i] = ST_IDLE;
               w_dcnt_nxt[i]  = CNT_ZERO;
               w_rcnt_nxt[i]  = CNT_ZERO;
               w_first_nxt[i] = 1'b1;
            end
         endcase
      end
   end

   // Output register: level from the current state, pulses from the events.
   always_ff @(posedge mclk) begin
      if (reset) begin
         r_key_level   <= {NKEYS{1'b0}};
         r_key_press   <= {NKEYS{1'b0}};
         r_key_release <= {NKEYS{1'b0}};
      end else begin
         for (int i = 0; i < NKEYS; i++) begin
            r_key_level[i] <= (r_state[i] == ST_HELD) || (r_state[i] == ST_DB_REL);
         end
         r_key_press   <= r_press_evt;
         r_key_release <= r_rel_evt;
      end
   end

   assign kb.key_level   = r_key_level;
   assign kb.key_press   = r_key_press;
   assign kb.key_release = r_key_release;

endmodule
